// File: rtl/led_breath_pwm_pkg.sv
// led_breath_pwm_pkg: phase encoding and default parameters shared by the breathing-LED block
package led_breath_pwm_pkg;
  typedef enum logic [2:0] {
    PH_IDLE    = 3'd0,
    PH_UP      = 3'd1,
    PH_HOLD_HI = 3'd2,
    PH_DOWN    = 3'd3,
    PH_HOLD_LO = 3'd4
  } phase_t;
  localparam int PWM_BITS_DEF   = 8;
  localparam int HOLD_STEPS_DEF = 16;
endpackage

// File: rtl/led_pwm_core.sv
// led_pwm_core: free-running PWM counter with period-boundary duty latch and registered LED compare
module led_pwm_core
  import led_breath_pwm_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                enable,
  input  logic [PWM_BITS-1:0] duty_next,
  output logic                LED
);
  localparam logic [PWM_BITS-1:0] MAX = '1;
  logic [PWM_BITS-1:0] pwm_cnt, duty;
  // duty only reloads on the last count so each period renders one level cleanly
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      pwm_cnt <= '0;
      duty    <= '0;
      LED     <= 1'b0;
    end else if (!enable) begin
      pwm_cnt <= '0;
      duty    <= '0;
      LED     <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (pwm_cnt == MAX) duty <= duty_next;
      LED <= pwm_cnt < duty;
    end
endmodule

// File: rtl/led_breath_pwm.sv
// led_breath_pwm: tick-driven breathing pattern FSM (up, hold, down, hold) rendered as PWM.
// Define LED_GAMMA_EN to square the level before PWM for a perceptually linear ramp.
module led_breath_pwm
  import led_breath_pwm_pkg::*;
#(
  parameter int PWM_BITS   = PWM_BITS_DEF,
  parameter int HOLD_STEPS = HOLD_STEPS_DEF
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                ENABLE,
  input  logic                STEP_TICK,
  output logic                LED,
  output logic [PWM_BITS-1:0] LEVEL,
  output logic [2:0]          PHASE,
  output logic                PERIOD_DONE
);
  localparam logic [PWM_BITS-1:0] MAX       = '1;
  localparam logic [7:0]          HOLD_LAST = 8'(HOLD_STEPS - 1);
  phase_t              state, state_n;
  logic [PWM_BITS-1:0] level_n, duty_next;
  logic [7:0]          hold_cnt, hold_n;
  logic                pd_n, hold_done;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state       <= PH_IDLE;
      LEVEL       <= '0;
      hold_cnt    <= '0;
      PERIOD_DONE <= 1'b0;
    end else begin
      state       <= state_n;
      LEVEL       <= level_n;
      hold_cnt    <= hold_n;
      PERIOD_DONE <= pd_n;
    end
  assign PHASE     = state;
  assign hold_done = hold_cnt == HOLD_LAST;
  always_comb begin
    state_n = state;
    level_n = LEVEL;
    hold_n  = hold_cnt;
    pd_n    = 1'b0;
    if (!ENABLE) begin
      state_n = PH_IDLE;
      level_n = '0;
      hold_n  = '0;
    end else
      case (state)
        PH_IDLE: begin
          state_n = PH_UP;
          level_n = '0;
        end
        PH_UP:
          if (STEP_TICK) begin
            level_n = LEVEL + 1'b1;
            if (level_n == MAX) begin
              state_n = PH_HOLD_HI;
              hold_n  = '0;
            end
          end
        PH_DOWN:
          if (STEP_TICK) begin
            level_n = LEVEL - 1'b1;
            if (level_n == '0) begin
              state_n = PH_HOLD_LO;
              hold_n  = '0;
            end
          end
        PH_HOLD_HI, PH_HOLD_LO:
          if (STEP_TICK) begin
            hold_n = hold_done ? '0 : hold_cnt + 1'b1;
            if (hold_done) begin
              state_n = (state == PH_HOLD_HI) ? PH_DOWN : PH_UP;
              pd_n    = state == PH_HOLD_LO;
            end
          end
        default: state_n = PH_IDLE;
      endcase
  end
`ifdef LED_GAMMA_EN
  assign duty_next = PWM_BITS'(({{PWM_BITS{1'b0}}, LEVEL} * {{PWM_BITS{1'b0}}, LEVEL}) >> PWM_BITS);
`else
  assign duty_next = LEVEL;
`endif
  led_pwm_core #(.PWM_BITS(PWM_BITS)) u_core (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .enable    (ENABLE && state != PH_IDLE),
    .duty_next (duty_next),
    .LED       (LED)
  );
endmodule

// File: tb/tb_led_breath_pwm.sv
// tb_led_breath_pwm: scoreboard bench; expected state changes and PWM window counts are queued by stimulus, checked by a monitor
module tb_led_breath_pwm;
  logic       CLK = 1'b0;
  logic       RST_N, ENABLE, STEP_TICK, LED, PERIOD_DONE;
  logic [3:0] LEVEL;
  logic [2:0] PHASE;
  int cyc = 0, total = 0, bad = 0, u, acc = 0;
  typedef struct {int c; int ph; int lv; int pd; string nm;} st_t;
  typedef struct {int start; int cnt; string nm;} pw_t;
  st_t sq[$];
  pw_t pq[$];
  st_t e;
  logic [7:0] last;
  led_breath_pwm #(.PWM_BITS(4), .HOLD_STEPS(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .ENABLE(ENABLE), .STEP_TICK(STEP_TICK),
    .LED(LED), .LEVEL(LEVEL), .PHASE(PHASE), .PERIOD_DONE(PERIOD_DONE)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  function automatic int f(int l);
`ifdef LED_GAMMA_EN
    return (l * l) >> 4;
`else
    return l;
`endif
  endfunction
  task automatic exp_st(int c, int ph, int lv, int pd, string nm);
    sq.push_back('{c, ph, lv, pd, nm});
  endtask
  task automatic goto(int c);
    while (cyc < c) begin
      @(posedge CLK);
      #1;
    end
  endtask
  always @(negedge CLK) begin
    if (!RST_N) begin
      total++;
      if ({LED, PHASE, LEVEL, PERIOD_DONE} !== 9'd0) begin
        bad++;
        $display("FAIL reset_zero cyc=%0d: led=%b ph=%0d lv=%0d pd=%b, want all 0", cyc, LED, PHASE, LEVEL, PERIOD_DONE);
      end
      last = {PHASE, LEVEL, PERIOD_DONE};
    end else begin
      if ({PHASE, LEVEL, PERIOD_DONE} !== last) begin
        last = {PHASE, LEVEL, PERIOD_DONE};
        total++;
        if (sq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_change cyc=%0d: ph=%0d lv=%0d pd=%b, want no change", cyc, PHASE, LEVEL, PERIOD_DONE);
        end else begin
          e = sq.pop_front();
          if (e.c != cyc || PHASE !== 3'(e.ph) || LEVEL !== 4'(e.lv) || PERIOD_DONE !== 1'(e.pd)) begin
            bad++;
            $display("FAIL %s: got ph=%0d lv=%0d pd=%b at cyc %0d, want ph=%0d lv=%0d pd=%0d at cyc %0d",
                     e.nm, PHASE, LEVEL, PERIOD_DONE, cyc, e.ph, e.lv, e.pd, e.c);
          end
        end
      end
      if (pq.size() > 0 && cyc >= pq[0].start) begin
        acc += int'(LED);
        if (cyc == pq[0].start + 15) begin
          total++;
          if (acc != pq[0].cnt) begin
            bad++;
            $display("FAIL %s: led high %0d of 16, want %0d", pq[0].nm, acc, pq[0].cnt);
          end
          acc = 0;
          void'(pq.pop_front());
        end
      end
    end
  end
  initial begin
    int wk[6] = '{1, 8, 10, 11, 21, 38};
    int wl[6] = '{0, 3, 3, 4, 8, 15};
    int c;
    RST_N = 1'b1; ENABLE = 1'b1; STEP_TICK = 1'b0;
    #2 RST_N = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge CLK);
      #1 STEP_TICK = ~STEP_TICK;
    end
    ENABLE = 1'b0; STEP_TICK = 1'b0;
    @(posedge CLK);
    #1 RST_N = 1'b1;
    goto(20);
    ENABLE = 1'b1;
    u = cyc + 1;
    exp_st(u, 1, 0, 0, "enable_up");
    // PWM period k occupies pwm cycles u+16k.., its LED output lags one cycle
    for (int i = 0; i < 6; i++) pq.push_back('{u + 16 * wk[i] + 1, f(wl[i]), $sformatf("pwm_level%0d_k%0d", wl[i], wk[i])});
    for (int j = 1; j <= 41; j++) begin
      goto(u + 40 * j - 1);
      STEP_TICK = 1'b1;
      c = u + 40 * j;
      if (j <= 14) exp_st(c, 1, j, 0, "ramp_up");
      else if (j == 15) exp_st(c, 2, 15, 0, "hold_hi");
      else if (j == 17) exp_st(c, 3, 15, 0, "down_enter");
      else if (j >= 18 && j <= 31) exp_st(c, 3, 32 - j, 0, "ramp_down");
      else if (j == 32) exp_st(c, 4, 0, 0, "hold_lo");
      else if (j == 34) begin
        exp_st(c, 1, 0, 1, "period_done");
        exp_st(c + 1, 1, 0, 0, "period_done_end");
      end else if (j >= 35) exp_st(c, 1, j - 34, 0, "ramp_up2");
      @(posedge CLK);
      #1 STEP_TICK = 1'b0;
    end
    goto(u + 1679);
    ENABLE = 1'b0; STEP_TICK = 1'b1;
    exp_st(u + 1680, 0, 0, 0, "disable_over_tick");
    pq.push_back('{u + 1680, 0, "led_off_idle"});
    @(posedge CLK);
    #1 STEP_TICK = 1'b0;
    goto(u + 1699);
    ENABLE = 1'b1; STEP_TICK = 1'b1;
    exp_st(u + 1700, 1, 0, 0, "reenable_tick_ignored");
    @(posedge CLK);
    #1 STEP_TICK = 1'b0;
    goto(u + 1709);
    STEP_TICK = 1'b1;
    exp_st(u + 1710, 1, 1, 0, "tick_after_reenable");
    @(posedge CLK);
    #1 STEP_TICK = 1'b0;
    goto(u + 1720);
    #2 RST_N = 1'b0;
    ENABLE = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;
    repeat (5) @(posedge CLK);
    #1;
    total++;
    if (sq.size() != 0) begin
      bad++;
      $display("FAIL state_queue_drained: %0d pending, want 0 (next %s)", sq.size(), sq[0].nm);
    end
    total++;
    if (pq.size() != 0) begin
      bad++;
      $display("FAIL pwm_queue_drained: %0d pending, want 0", pq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
